// File: rtl/gated_q_event_logger_if.sv
// Event-logger bus: edge source input, valid/ready event stream and overflow status.
// The slave modport is the logger; the master modport is the upstream stage plus trace reader.
interface gated_q_event_logger_if #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 4,
  parameter int OVF_W = 8
);
  logic                     y_in;
  logic                     log_en;
  logic                     ev_valid;
  logic                     ev_ready;
  logic [TS_W:0]            ev_data;
  logic [$clog2(DEPTH):0]   ev_count;
  logic                     ovf_flag;
  logic [OVF_W-1:0]         ovf_cnt;
  logic                     clr_ovf;

  modport slave (
    input  y_in, log_en, ev_ready, clr_ovf,
    output ev_valid, ev_data, ev_count, ovf_flag, ovf_cnt
  );

  modport master (
    output y_in, log_en, ev_ready, clr_ovf,
    input  ev_valid, ev_data, ev_count, ovf_flag, ovf_cnt
  );
endinterface

// File: rtl/gated_q_event_logger.sv
// Timestamps edges of the gated upstream output y into a show-ahead FIFO with overflow accounting.
// Optional macro LOG_FALL_EDGE_EN also logs falling edges (type bit = 1).
module gated_q_event_logger #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 4,
  parameter int OVF_W = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  gated_q_event_logger_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [TS_W-1:0]  r_ts;
  logic             r_y_prev;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [TS_W:0]    r_mem [DEPTH];
  logic             r_ovf_flag;
  logic [OVF_W-1:0] r_ovf_cnt;

  logic          w_rise;
  logic          w_fall;
  logic          w_push_req;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [TS_W:0] w_entry;

  assign w_rise = bus.y_in & ~r_y_prev;
`ifdef LOG_FALL_EDGE_EN
  assign w_fall = ~bus.y_in & r_y_prev;
`else
  assign w_fall = 1'b0;
`endif

  // The entry carries the timestamp of the cycle in which the new y level was sampled.
  assign w_entry    = {w_fall, r_ts};
  assign w_push_req = bus.log_en & (w_rise | w_fall);
  assign w_empty    = (r_wptr == r_rptr);
  assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop      = ~w_empty & bus.ev_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ts       <= '0;
      r_y_prev   <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_ovf_flag <= 1'b0;
      r_ovf_cnt  <= '0;
    end else begin
      r_ts     <= r_ts + TS_W'(1);
      r_y_prev <= bus.y_in;
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      // Clear first, then a same-cycle drop counts as the first new one.
      if (bus.clr_ovf) begin
        r_ovf_flag <= w_drop;
        r_ovf_cnt  <= w_drop ? OVF_W'(1) : '0;
      end else if (w_drop) begin
        r_ovf_flag <= 1'b1;
        if (r_ovf_cnt != '1) r_ovf_cnt <= r_ovf_cnt + OVF_W'(1);
      end
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= w_entry;
  end

  // NOTE: every output driven here gets a default first, so no latch can be inferred.
  always_comb begin
    bus.ev_data = '0;
    if (!w_empty) bus.ev_data = r_mem[r_rptr[AW-1:0]];
  end

  assign bus.ev_valid = ~w_empty;
  assign bus.ev_count = r_wptr - r_rptr;
  assign bus.ovf_flag = r_ovf_flag;
  assign bus.ovf_cnt  = r_ovf_cnt;
endmodule

// File: tb/tb_gated_q_event_logger.sv
// Directed bench for gated_q_event_logger: latency, overflow, same-cycle push/pop, wrap, reset.
// Build with LOG_FALL_EDGE_EN defined to exercise the falling-edge path instead of the overflow steps.
module tb_gated_q_event_logger;
  localparam int TS_W  = 16;
  localparam int DEPTH = 4;
  localparam int OVF_W = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [15:0] cyc;
  logic [15:0] t2, t3, t4, tn, tr, tf, tx;

  gated_q_event_logger_if #(.TS_W(TS_W), .DEPTH(DEPTH), .OVF_W(OVF_W)) bus ();

  gated_q_event_logger #(.TS_W(TS_W), .DEPTH(DEPTH), .OVF_W(OVF_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge; cyc mirrors the timestamp the DUT holds after that edge.
  task automatic tick();
    @(posedge clk);
    cyc = cyc + 16'd1;
    #1;
  endtask

  task automatic rise_pulse(output logic [15:0] t);
    bus.y_in = 1'b0;
    tick();
    bus.y_in = 1'b1;
    t = cyc;
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = '0;
    rst_n       = 1'b0;
    bus.y_in    = 1'b0;
    bus.log_en  = 1'b1;
    bus.ev_ready = 1'b0;
    bus.clr_ovf = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.ev_valid), 32'd0);
    check("rst_count", 32'(bus.ev_count), 32'd0);
    check("rst_data",  32'(bus.ev_data),  32'd0);
    check("rst_flag",  32'(bus.ovf_flag), 32'd0);
    check("rst_cnt",   32'(bus.ovf_cnt),  32'd0);
    rst_n = 1'b1;
    cyc   = '0;

    // First rise sampled at the fifth edge after release carries ts 4
    repeat (4) tick();
    bus.y_in = 1'b1;
    tick();
    check("t1_valid", 32'(bus.ev_valid), 32'd1);
    check("t1_data",  32'(bus.ev_data),  32'h0_0004);
    check("t1_count", 32'(bus.ev_count), 32'd1);

`ifdef LOG_FALL_EDGE_EN
    // High-then-low pulse of 3 cycles yields a rise then a fall
    #3;
    rst_n = 1'b0;
    bus.y_in = 1'b0;
    #1;
    check("f_rst_count", 32'(bus.ev_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = '0;
    repeat (2) tick();
    bus.y_in = 1'b1;
    tr = cyc;
    repeat (3) tick();
    bus.y_in = 1'b0;
    tf = cyc;
    tick();
    check("f_count", 32'(bus.ev_count), 32'd2);
    check("f_rise",  32'(bus.ev_data),  32'({1'b0, tr}));
    bus.ev_ready = 1'b1;
    tick();
    bus.ev_ready = 1'b0;
    check("f_fall",  32'(bus.ev_data),  32'({1'b1, tf}));
    check("f_width", 32'(bus.ev_data[15:0] - tr), 32'd3);
    check("f_count2", 32'(bus.ev_count), 32'd1);
`else
    // Fill to DEPTH, then overflow
    rise_pulse(t2);
    rise_pulse(t3);
    rise_pulse(t4);
    check("t2_full_count", 32'(bus.ev_count), 32'd4);
    check("t2_no_ovf", 32'(bus.ovf_flag), 32'd0);
    rise_pulse(tx);
    check("t2_ovf_flag", 32'(bus.ovf_flag), 32'd1);
    check("t2_ovf_cnt",  32'(bus.ovf_cnt),  32'd1);
    check("t2_head",     32'(bus.ev_data),  32'h0_0004);
    for (int i = 0; i < 300; i++) rise_pulse(tx);
    check("t2_ovf_sat",  32'(bus.ovf_cnt),  32'd255);
    check("t2_count",    32'(bus.ev_count), 32'd4);

    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    check("clr_cnt",  32'(bus.ovf_cnt),  32'd0);
    check("clr_flag", 32'(bus.ovf_flag), 32'd0);

    // Full FIFO: push and pop together is not an overflow
    bus.y_in = 1'b0;
    tick();
    bus.y_in = 1'b1;
    bus.ev_ready = 1'b1;
    tn = cyc;
    tick();
    check("t3_count", 32'(bus.ev_count), 32'd4);
    check("t3_flag",  32'(bus.ovf_flag), 32'd0);
    check("t3_cnt",   32'(bus.ovf_cnt),  32'd0);
    check("t3_head",  32'(bus.ev_data),  32'({1'b0, t2}));
    repeat (3) tick();
    check("t3_tail",  32'(bus.ev_data),  32'({1'b0, tn}));
    check("t3_count1", 32'(bus.ev_count), 32'd1);
    tick();
    bus.ev_ready = 1'b0;
    check("t3_empty_valid", 32'(bus.ev_valid), 32'd0);
    check("t3_empty_data",  32'(bus.ev_data),  32'd0);

    // Edge while log_en=0 is consumed; re-enabling with y high logs nothing
    bus.y_in = 1'b0;
    bus.log_en = 1'b0;
    tick();
    bus.y_in = 1'b1;
    tick();
    check("t4_gated", 32'(bus.ev_count), 32'd0);
    bus.log_en = 1'b1;
    tick();
    check("t4_reen", 32'(bus.ev_valid), 32'd0);
    rise_pulse(tr);
    check("t4_count", 32'(bus.ev_count), 32'd1);
    check("t4_data",  32'(bus.ev_data),  32'({1'b0, tr}));
    bus.ev_ready = 1'b1;
    tick();
    bus.ev_ready = 1'b0;

    // Timestamp wrap: rise at ts FFFF, next possible rise at ts 0001
    bus.y_in = 1'b0;
    while (cyc != 16'hFFFF) tick();
    bus.y_in = 1'b1;
    tick();
    check("t5_ffff", 32'(bus.ev_data), 32'h0_FFFF);
    rise_pulse(tx);
    check("t5_count2", 32'(bus.ev_count), 32'd2);
    bus.ev_ready = 1'b1;
    tick();
    bus.ev_ready = 1'b0;
    check("t5_wrap", 32'(bus.ev_data), 32'h0_0001);
    rise_pulse(tx);
    rise_pulse(tx);
    rise_pulse(tx);
    check("t5_full", 32'(bus.ev_count), 32'd4);
    rise_pulse(tx);
    rise_pulse(tx);
    check("t5_cnt2", 32'(bus.ovf_cnt), 32'd2);
    bus.y_in = 1'b0;
    tick();
    bus.y_in = 1'b1;
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    check("t5_clr_drop_cnt",  32'(bus.ovf_cnt),  32'd1);
    check("t5_clr_drop_flag", 32'(bus.ovf_flag), 32'd1);
    check("t5_head", 32'(bus.ev_data), 32'h0_0001);

    // Asynchronous reset with 3 queued events
    bus.ev_ready = 1'b1;
    tick();
    bus.ev_ready = 1'b0;
    check("t6_count3", 32'(bus.ev_count), 32'd3);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_valid", 32'(bus.ev_valid), 32'd0);
    check("t6_count", 32'(bus.ev_count), 32'd0);
    check("t6_data",  32'(bus.ev_data),  32'd0);
    check("t6_flag",  32'(bus.ovf_flag), 32'd0);
    check("t6_cnt",   32'(bus.ovf_cnt),  32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = '0;
    // y already high at the first edge after release is a rise at ts 0
    tick();
    check("t6_first_rise_count", 32'(bus.ev_count), 32'd1);
    check("t6_first_rise_data",  32'(bus.ev_data),  32'h0_0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
